// File: rtl/ifu_fetch_if.sv
// Fetch-side bus bundle: the instruction-memory request/response channel and the IDU handoff.
// The fetch unit is the master; memory and decode together form the slave side.
interface ifu_fetch_if #(
   parameter int WIDTH = 64
);
   logic             imem_req_valid;
   logic             imem_req_ready;
   logic [WIDTH-1:0] imem_req_addr;
   logic             imem_resp_valid;
   logic [31:0]      imem_resp_data;
   logic             imem_resp_err;
   logic             id_valid;
   logic             id_ready;
   logic [31:0]      id_inst;
   logic [WIDTH-1:0] id_pc;
   logic             id_fault;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready,
      input  imem_resp_valid, imem_resp_data, imem_resp_err,
      output id_valid, id_inst, id_pc, id_fault,
      input  id_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready,
      output imem_resp_valid, imem_resp_data, imem_resp_err,
      input  id_valid, id_inst, id_pc, id_fault,
      output id_ready
   );
endinterface

// File: rtl/ifu_fetch.sv
// Multicycle RV64 fetch unit: owns the PC, keeps one imem read in flight at most,
// and hands each fetched word to decode, applying branch/trap/mret/flush redirects.
module ifu_fetch #(
   parameter int               WIDTH    = 64,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(64'h8000_0000)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             br_taken_i,
   input  logic [WIDTH-1:0] br_target_i,
   input  logic             ex_i,
   input  logic [WIDTH-1:0] ex_entry_i,
   input  logic             ex_ret_i,
   input  logic [WIDTH-1:0] epc_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] flush_target_i,
   ifu_fetch_if.master      bus,
   output logic [WIDTH-1:0] pc_o,
   output logic [WIDTH-1:0] nextpc_o
);

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_VALID,
      S_DROP
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic             req_valid_q, req_valid_d;
   logic [WIDTH-1:0] req_addr_q, req_addr_d;
   logic             id_valid_q, id_valid_d;
   logic [31:0]      id_inst_q, id_inst_d;
   logic [WIDTH-1:0] id_pc_q, id_pc_d;
   logic             id_fault_q, id_fault_d;
   logic             drop_pending_q, drop_pending_d;
   logic [WIDTH-1:0] next_pc;

   always_comb begin
      if (flush_i)         next_pc = flush_target_i;
      else if (ex_i)       next_pc = ex_entry_i;
      else if (ex_ret_i)   next_pc = epc_i;
      else if (br_taken_i) next_pc = {br_target_i[WIDTH-1:1], 1'b0};
      else                 next_pc = pc_q + WIDTH'(4);
   end

   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      req_valid_d    = req_valid_q;
      req_addr_d     = req_addr_q;
      id_valid_d     = id_valid_q;
      id_inst_d      = id_inst_q;
      id_pc_d        = id_pc_q;
      id_fault_d     = id_fault_q;
      drop_pending_d = drop_pending_q;

      unique case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
            if (flush_i) pc_d = flush_target_i;
         end
         S_REQ: begin
            if (req_valid_q) begin
               // A held request is never withdrawn; a flush only marks its response as stale.
               if (flush_i) pc_d = flush_target_i;
               if (bus.imem_req_ready) begin
                  req_valid_d    = 1'b0;
                  drop_pending_d = 1'b0;
                  state_d        = (drop_pending_q || flush_i) ? S_DROP : S_WAIT;
               end else if (flush_i) begin
                  drop_pending_d = 1'b1;
               end
            end else if (flush_i) begin
               pc_d = flush_target_i;
            end else if (pc_q[1:0] != 2'b00) begin
               id_valid_d = 1'b1;
               id_inst_d  = NOP_INST;
               id_fault_d = 1'b1;
               id_pc_d    = pc_q;
               state_d    = S_VALID;
            end
         end
         S_WAIT: begin
            if (flush_i) begin
               pc_d    = flush_target_i;
               state_d = bus.imem_resp_valid ? S_REQ : S_DROP;
            end else if (bus.imem_resp_valid) begin
               id_valid_d = 1'b1;
               id_inst_d  = bus.imem_resp_data;
               id_fault_d = bus.imem_resp_err;
               id_pc_d    = pc_q;
               state_d    = S_VALID;
            end
         end
         S_VALID: begin
            // Flush wins over retire; a same-cycle id_ready still consumes the instruction.
            if (flush_i || bus.id_ready) begin
               pc_d       = next_pc;
               id_valid_d = 1'b0;
               state_d    = S_REQ;
            end
         end
         S_DROP: begin
            if (flush_i) pc_d = flush_target_i;
            if (bus.imem_resp_valid) state_d = S_REQ;
         end
         default: state_d = S_IDLE;
      endcase

      // Entering REQ on an aligned PC with nothing held launches the request next cycle.
      if (state_d == S_REQ && !req_valid_d && pc_d[1:0] == 2'b00) begin
         req_valid_d = 1'b1;
         req_addr_d  = pc_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         pc_q           <= RESET_PC;
         req_valid_q    <= 1'b0;
         req_addr_q     <= RESET_PC;
         id_valid_q     <= 1'b0;
         id_inst_q      <= '0;
         id_pc_q        <= RESET_PC;
         id_fault_q     <= 1'b0;
         drop_pending_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         req_valid_q    <= req_valid_d;
         req_addr_q     <= req_addr_d;
         id_valid_q     <= id_valid_d;
         id_inst_q      <= id_inst_d;
         id_pc_q        <= id_pc_d;
         id_fault_q     <= id_fault_d;
         drop_pending_q <= drop_pending_d;
      end
   end

   assign bus.imem_req_valid = req_valid_q;
   assign bus.imem_req_addr  = req_addr_q;
   assign bus.id_valid       = id_valid_q;
   assign bus.id_inst        = id_inst_q;
   assign bus.id_pc          = id_pc_q;
   assign bus.id_fault       = id_fault_q;
   assign pc_o               = pc_q;
   assign nextpc_o           = next_pc;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios with literal expectations, then randomized redirects,
// backpressure and memory latency checked every cycle against a PC-level architectural model.
module tb_ifu_fetch;
   localparam int          W      = 64;
   localparam logic [63:0] RST_PC = 64'h8000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        br_taken = 1'b0;
   logic [63:0] br_target = '0;
   logic        ex = 1'b0;
   logic [63:0] ex_entry = '0;
   logic        ex_ret = 1'b0;
   logic [63:0] epc = '0;
   logic        flush = 1'b0;
   logic [63:0] flush_target = '0;
   logic [63:0] pc_o, nextpc_o;

   always #5 clk = ~clk;

   ifu_fetch_if #(.WIDTH(W)) bus ();

   ifu_fetch #(.WIDTH(W), .RESET_PC(RST_PC)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .br_taken_i     (br_taken),
      .br_target_i    (br_target),
      .ex_i           (ex),
      .ex_entry_i     (ex_entry),
      .ex_ret_i       (ex_ret),
      .epc_i          (epc),
      .flush_i        (flush),
      .flush_target_i (flush_target),
      .bus            (bus),
      .pc_o           (pc_o),
      .nextpc_o       (nextpc_o)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int n_hs     = 0;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // ---------------- memory: contents and faults are pure functions of the address ----------------
   int          mem_lat   = 1;
   int          ready_pct = 100;
   bit          err_force = 1'b0;
   bit          err_rand  = 1'b0;
   bit          mem_pending = 1'b0;
   int          mem_cnt = 0;
   logic [63:0] mem_addr = '0;

   function automatic logic [31:0] mem_data(input logic [63:0] a);
      return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic mem_err(input logic [63:0] a);
      logic [31:0] d;
      d = mem_data(a);
      return err_force || (err_rand && d[11:8] == 4'h0);
   endfunction

   initial begin
      bus.imem_req_ready  = 1'b0;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = '0;
      bus.imem_resp_err   = 1'b0;
      forever begin
         @(posedge clk); #1;
         bus.imem_resp_valid = 1'b0;
         if (mem_pending) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
               bus.imem_resp_valid = 1'b1;
               bus.imem_resp_data  = mem_data(mem_addr);
               bus.imem_resp_err   = mem_err(mem_addr);
               mem_pending         = 1'b0;
            end
         end
         bus.imem_req_ready = ($urandom_range(0, 99) < ready_pct);
         @(negedge clk); #4;
         if (rst_n && bus.imem_req_valid && bus.imem_req_ready) begin
            mem_pending = 1'b1;
            mem_cnt     = mem_lat;
            mem_addr    = bus.imem_req_addr;
         end
      end
   end

   // ---------------- architectural model: PC moves only on retire or flush ----------------
   function automatic logic [63:0] model_next(input logic [63:0] p);
      if (flush)    return flush_target;
      if (ex)       return ex_entry;
      if (ex_ret)   return epc;
      if (br_taken) return br_target & ~64'd1;
      return p + 64'd4;
   endfunction

   initial begin
      logic [63:0] m_pc, exp_next, p_req_addr;
      logic        p_req_hold, p_idv_hold, p_id_leave, mis;
      logic [97:0] p_id;
      m_pc = RST_PC; p_req_hold = 0; p_idv_hold = 0; p_id_leave = 0; p_req_addr = '0; p_id = '0;
      forever begin
         @(negedge clk); #3;
         if (!rst_n) begin
            m_pc = RST_PC; p_req_hold = 0; p_idv_hold = 0; p_id_leave = 0;
         end else begin
            exp_next = model_next(m_pc);
            check("pc", pc_o, m_pc);
            check("nextpc", nextpc_o, exp_next);
            if (p_req_hold) begin
               check("req_hold_valid", bus.imem_req_valid, 1);
               check("req_hold_addr", bus.imem_req_addr, p_req_addr);
            end
            if (bus.imem_req_valid) begin
               check("req_align", bus.imem_req_addr[1:0], 0);
               check("req_one_outstanding", mem_pending, 0);
               check("req_while_id_valid", bus.id_valid, 0);
            end
            if (p_idv_hold)
               check("id_stable", {bus.id_valid, bus.id_pc, bus.id_inst, bus.id_fault}, p_id);
            if (p_id_leave) check("id_valid_drop", bus.id_valid, 0);
            if (bus.id_valid) begin
               mis = (m_pc[1:0] != 2'b00);
               check("id_pc", bus.id_pc, m_pc);
               check("id_inst", bus.id_inst, mis ? 32'h0000_0013 : mem_data(m_pc));
               check("id_fault", bus.id_fault, mis ? 1'b1 : mem_err(m_pc));
               if (bus.id_ready) begin
                  n_hs++;
                  $display("retire pc=%h inst=%h fault=%0d flush=%0d", bus.id_pc, bus.id_inst,
                           bus.id_fault, flush);
               end
            end
            p_req_hold = bus.imem_req_valid && !bus.imem_req_ready;
            p_req_addr = bus.imem_req_addr;
            p_idv_hold = bus.id_valid && !bus.id_ready && !flush;
            p_id       = {bus.id_valid, bus.id_pc, bus.id_inst, bus.id_fault};
            p_id_leave = bus.id_valid && (bus.id_ready || flush);
            if (flush) m_pc = flush_target;
            else if (bus.id_valid && bus.id_ready) m_pc = exp_next;
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic clear_redirects();
      br_taken = 0; ex = 0; ex_ret = 0; flush = 0;
   endtask

   // Called at a negedge while id_valid is high.
   task automatic retire(input logic b, input logic [63:0] bt, input logic e, input logic [63:0] ee,
                         input logic r, input logic [63:0] ep);
      br_taken = b; br_target = bt; ex = e; ex_entry = ee; ex_ret = r; epc = ep;
      bus.id_ready = 1'b1;
      @(posedge clk); #1;
      clear_redirects();
      bus.id_ready = 1'b0;
   endtask

   task automatic wait_id(input string name, output bit seen_req);
      bit done;
      seen_req = 0; done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (bus.imem_req_valid) seen_req = 1;
         if (bus.id_valid) done = 1;
      end
      if (!done) check({name, "_id_timeout"}, bus.id_valid, 1);
   endtask

   task automatic wait_req(input string name, output logic [63:0] addr);
      bit done;
      done = 0; addr = '0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (bus.imem_req_valid && bus.imem_req_ready) begin
            done = 1; addr = bus.imem_req_addr;
         end
      end
      if (!done) check({name, "_req_timeout"}, bus.imem_req_valid, 1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [63:0]  a;
      logic [97:0]  hold;
      bit           s;
      int           hs, hs_before;
      bus.id_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_valid", bus.imem_req_valid, 0);
      check("rst_req_addr", bus.imem_req_addr, RST_PC);
      check("rst_id_valid", bus.id_valid, 0);
      check("rst_id_inst", bus.id_inst, 0);
      check("rst_id_pc", bus.id_pc, RST_PC);
      check("rst_id_fault", bus.id_fault, 0);
      check("rst_pc", pc_o, RST_PC);

      // Sequential fetch, 1-cycle ready/response: one instruction every 3 cycles.
      bus.id_ready = 1'b1;
      rst_n = 1'b1;
      @(negedge clk); check("c0_req_valid", bus.imem_req_valid, 0);
      @(negedge clk); check("c1_req_valid", bus.imem_req_valid, 1);
      check("c1_req_addr", bus.imem_req_addr, RST_PC);
      hs = 0;
      for (int c = 2; c < 20 && hs < 3; c++) begin
         @(negedge clk);
         if (bus.id_valid) begin
            check($sformatf("seq%0d_cycle", hs), c, 3 * (hs + 1));
            check($sformatf("seq%0d_pc", hs), bus.id_pc, RST_PC + 64'(4 * hs));
            hs++;
            if (hs == 3) begin
               br_taken = 1'b1; br_target = 64'h8000_0101;
            end
         end
      end
      check("seq_count", hs, 3);
      @(posedge clk); #1;
      clear_redirects();
      bus.id_ready = 1'b0;

      wait_req("branch", a);
      check("branch_req_addr", a, 64'h8000_0100);
      wait_id("branch", s);
      check("branch_id_pc", bus.id_pc, 64'h8000_0100);
      retire(1, 64'h8000_4000, 1, 64'h8000_1000, 1, 64'h8000_3000);
      wait_req("prio", a);
      check("prio_req_addr", a, 64'h8000_1000);

      wait_id("prio", s);
      retire(1, 64'h8000_0102, 0, 0, 0, 0);
      wait_id("misalign", s);
      check("misalign_no_req", s, 0);
      check("misalign_valid", bus.id_valid, 1);
      check("misalign_fault", bus.id_fault, 1);
      check("misalign_inst", bus.id_inst, 32'h0000_0013);
      check("misalign_pc", bus.id_pc, 64'h8000_0102);

      // Flush during a 5-cycle wait: the stale word must never reach decode.
      mem_lat = 5;
      retire(1, 64'h8000_0200, 0, 0, 0, 0);
      wait_req("preflush", a);
      check("preflush_req_addr", a, 64'h8000_0200);
      @(negedge clk);
      flush = 1'b1; flush_target = 64'h8000_2000;
      @(posedge clk); #1;
      flush = 1'b0;
      mem_lat = 1;
      err_force = 1'b1;
      wait_req("flush", a);
      check("flush_req_addr", a, 64'h8000_2000);
      wait_id("flush", s);
      check("flush_id_pc", bus.id_pc, 64'h8000_2000);
      check("flush_id_inst", bus.id_inst, mem_data(64'h8000_2000));
      check("err_fault", bus.id_fault, 1);

      // Backpressure with a faulted word: outputs frozen, no new request.
      hold = {1'b1, bus.id_pc, bus.id_inst, bus.id_fault};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("bp_stable%0d", i), {bus.id_valid, bus.id_pc, bus.id_inst, bus.id_fault}, hold);
         check($sformatf("bp_no_req%0d", i), bus.imem_req_valid, 0);
      end
      retire(0, 0, 0, 0, 0, 0);
      err_force = 1'b0;
      mem_lat = 5;
      wait_req("after_err", a);
      check("after_err_req_addr", a, 64'h8000_2004);

      // Reset mid-flight; the old response lands after release and must be ignored.
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("async_rst_pc", pc_o, RST_PC);
      check("async_rst_id_valid", bus.id_valid, 0);
      check("async_rst_req_valid", bus.imem_req_valid, 0);
      check("async_rst_id_pc", bus.id_pc, RST_PC);
      mem_lat = 1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      wait_id("post_rst", s);
      check("post_rst_id_pc", bus.id_pc, RST_PC);
      check("post_rst_id_inst", bus.id_inst, mem_data(RST_PC));
      retire(0, 0, 0, 0, 0, 0);

      // Randomized phase.
      hs_before = n_hs;
      err_rand  = 1'b1;
      ready_pct = 60;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         mem_lat      = $urandom_range(1, 5);
         bus.id_ready = ($urandom_range(0, 3) != 0);
         br_taken     = ($urandom_range(0, 3) == 0);
         br_target    = RST_PC + 64'($urandom_range(0, 4095));
         ex           = ($urandom_range(0, 15) == 0);
         ex_entry     = 64'h8000_8000 + (64'($urandom_range(0, 255)) << 2);
         ex_ret       = ($urandom_range(0, 15) == 0);
         epc          = RST_PC + (64'($urandom_range(0, 1023)) << 1);
         flush        = ($urandom_range(0, 31) == 0);
         flush_target = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8
                                                    : RST_PC + (64'($urandom_range(0, 1023)) << 2);
      end
      @(posedge clk); #1;
      clear_redirects();
      bus.id_ready = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("random_progress", (n_hs - hs_before) >= 50, 1);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Multicycle instruction fetch unit for the RV64 core. It owns the architectural PC, issues one instruction-memory read at a time over a valid/ready request channel, and presents each fetched instruction to the decode stage (IDU) through a valid/ready handshake. It computes the next PC from the branch, exception, exception-return and flush redirects supplied by downstream stages and the CSR unit. It replaces the combinational fetch path so the core can run with memories that have variable latency.

## Interface
- WIDTH, 64, datapath/PC width
- RESET_PC, 64'h8000_0000, PC loaded on reset
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- br_taken  in  1  taken branch/jump of the retiring instruction
- br_target  in  WIDTH  branch target; bit 0 is forced to 0 on use
- ex  in  1  exception raised by the retiring instruction
- ex_entry  in  WIDTH  trap vector
- ex_ret  in  1  mret retiring
- epc  in  WIDTH  return PC from CSR
- flush  in  1  asynchronous-to-retire redirect (fence.i, debug); valid in any state
- flush_target  in  WIDTH  flush destination
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  WIDTH  fetch address
- imem_resp_valid  in  1  read data valid (single-cycle pulse, always accepted)
- imem_resp_data  in  32  instruction word
- imem_resp_err  in  1  access fault with response
- id_valid  out  1  instruction valid to IDU
- id_ready  in  1  IDU retires/consumes instruction
- id_inst  out  32  instruction word
- id_pc  out  WIDTH  PC of id_inst
- id_fault  out  1  fetch fault (misaligned or access error)
- pc  out  WIDTH  current fetch PC
- nextpc  out  WIDTH  PC after the current instruction (combinational)

## Operation
- States: IDLE, REQ, WAIT, VALID, DROP. Reset -> IDLE.
- IDLE: one cycle, then REQ.
- REQ: If pc[1:0] != 0, do not issue a request. Load id_inst=32'h0000_0013, id_fault=1, id_pc=pc, then go to VALID. Otherwise assert imem_req_valid with imem_req_addr=pc. When imem_req_ready is high, go to WAIT.
- Request rule: once imem_req_valid is asserted, the address is held in a separate req_addr register. Both valid and address stay stable until accepted.
- WAIT: On imem_resp_valid, capture id_inst=imem_resp_data, id_fault=imem_resp_err, id_pc=pc, then go to VALID.
- VALID: id_valid=1. On id_valid & id_ready: pc <= nextpc, then go to REQ.
- nextpc priority: flush_target > ex_entry (ex) > epc (ex_ret) > {br_target[63:1],1'b0} (br_taken) > pc+4.
- Redirect inputs other than flush are meaningful only in the handshake cycle and are ignored otherwise.
- pc+4 wraps modulo 2^WIDTH.
- Flush handling by state:
  - IDLE: pc <= flush_target.
  - VALID: pc <= flush_target, id_valid drops next cycle, go to REQ. This applies even if id_ready is high in the same cycle; the instruction counts as consumed.
  - REQ with the request not yet accepted: pc <= flush_target and drop_pending <= 1. The held request continues, and on acceptance the state goes to DROP.
  - REQ with the request accepted in the flush cycle, or WAIT without a same-cycle response: pc <= flush_target, go to DROP.
  - WAIT with imem_resp_valid in the same cycle: discard the response, go to REQ.
- DROP: Wait for imem_resp_valid and discard it; id_valid stays 0. Then go to REQ. A flush during DROP only updates pc.
- At most one outstanding memory request at any time.

## Timing
- Reset values: imem_req_valid=0, imem_req_addr=RESET_PC, id_valid=0, id_inst=0, id_pc=RESET_PC, id_fault=0, pc=RESET_PC, drop_pending=0.
- After rst deasserts: IDLE for cycle 0, and imem_req_valid is first high in cycle 1.
- Best-case latency: request accepted in cycle N, response in N+1, id_valid high in N+2.
- Throughput is at most one instruction per 3 cycles.
- id_valid, id_inst, id_pc and id_fault are registered and stay stable while id_valid=1 and id_ready=0.
- nextpc is combinational from pc and the redirect inputs. pc and id_pc change only at edges.
- Reset asserted mid-operation returns all state to reset values immediately. A response to a pre-reset request arriving after reset is ignored because the state is not WAIT or DROP.

## Test plan
- Reset and sequential fetch, memory with 1-cycle ready and 1-cycle response: PCs 0x8000_0000, 0x8000_0004, 0x8000_0008 are presented with id_valid every 3 cycles. The first imem_req_valid occurs in cycle 1 after reset.
- Taken branch: at retire of pc 0x8000_0008 with br_taken=1 and br_target=0x8000_0101, the next request address is 0x8000_0100.
- Priority: ex=1, ex_ret=1 and br_taken=1 in the same handshake. The next fetch address is ex_entry (0x8000_1000).
- Misaligned target: branch to 0x8000_0102 produces no memory request. id_valid=1, id_fault=1, id_inst=0x0000_0013, id_pc=0x8000_0102.
- Flush during WAIT with a 5-cycle response: the stale response is dropped and never reaches the IDU. The next request goes to flush_target 0x8000_2000.
- Backpressure and access error: with id_ready held low for 4 cycles, the id_* outputs stay stable. With imem_resp_err=1, id_fault=1 and the next request is not issued until the handshake.
